// File: rtl/ram_pkg.sv
// Shared definitions for the RAM BIST controller: default geometry,
// sequencer state encoding and the address-derived test pattern.
package ram_pkg;

    localparam int unsigned     RAM_ADDR_W  = 12;
    localparam int unsigned     RAM_DATA_W  = 8;
    localparam logic [7:0]      RAM_PATTERN = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR0,
        ST_RD0,
        ST_WR1,
        ST_RD1,
        ST_DRAIN,
        ST_DONE
    } bist_state_t;

    // D(a,p): low address byte folded with the upper nibble so that aliasing
    // of addr[11:8] shows up, XORed with the seed, inverted on pass 1.
    function automatic logic [RAM_DATA_W-1:0] bist_word(
        input logic [RAM_ADDR_W-1:0] a,
        input logic                  p,
        input logic [RAM_DATA_W-1:0] seed
    );
        return (a[7:0] ^ {a[11:8], a[11:8]} ^ seed) ^ {RAM_DATA_W{p}};
    endfunction

endpackage

// File: rtl/ram_bist_datagen.sv
// Combinational test-word generator D(addr, pass).
module ram_bist_datagen
    import ram_pkg::*;
#(
    parameter int unsigned          ADDR_W  = RAM_ADDR_W,
    parameter int unsigned          DATA_W  = RAM_DATA_W,
    parameter logic [DATA_W-1:0]    PATTERN = RAM_PATTERN
)(
    input  logic [ADDR_W-1:0] addr,
    input  logic              pass,
    output logic [DATA_W-1:0] word
);

    // Pattern word for the given address and pass
    always_comb begin
        word = bist_word(addr, pass, PATTERN);
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM built-in self-test sequencer: write/read-back of the whole array with
// an address-derived pattern and then its inverse, with error capture.
module ram_bist_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned          ADDR_W  = RAM_ADDR_W,
    parameter int unsigned          DATA_W  = RAM_DATA_W,
    parameter logic [DATA_W-1:0]    PATTERN = RAM_PATTERN,
    parameter int unsigned          RD_LAT  = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic              first_err_pass,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    bist_state_t        state, state_nxt;
    logic [ADDR_W-1:0]  cnt, cnt_nxt;
    logic               issue_we, issue_rd, issue_pass, launch, active_nxt;
    logic [DATA_W-1:0]  din_word, exp_word;
    logic               mismatch;
    logic [ADDR_W+1:0]  err_sum;

    // Compare pipeline: stage k holds the read issued k cycles ago; stage
    // RD_LAT lines up with ram_dout for that read.
    logic               pv [0:RD_LAT];
    logic [ADDR_W-1:0]  pa [0:RD_LAT];
    logic               pp [0:RD_LAT];
    logic [DATA_W-1:0]  pe [0:RD_LAT];

    // State and address counter register; cnt always equals the address of
    // the operation in flight this cycle (or the drain count in DRAIN)
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: phases advance on the counter wrap, DRAIN waits RD_LAT cycles
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_WR0;
                    cnt_nxt   = '0;
                end
            end
            ST_WR0: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == '1) state_nxt = ST_RD0;
            end
            ST_RD0: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == '1) state_nxt = ST_WR1;
            end
            ST_WR1: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == '1) state_nxt = ST_RD1;
            end
            ST_RD1: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == '1) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == ADDR_W'(RD_LAT - 1)) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the RAM port can be registered
    always_comb begin
        issue_we   = (state_nxt == ST_WR0) || (state_nxt == ST_WR1);
        issue_rd   = (state_nxt == ST_RD0) || (state_nxt == ST_RD1);
        issue_pass = (state_nxt == ST_WR1) || (state_nxt == ST_RD1);
        active_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
        launch     = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    end

    ram_bist_datagen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PATTERN(PATTERN)) u_gen_din (
        .addr (cnt_nxt),
        .pass (issue_pass),
        .word (din_word)
    );

    ram_bist_datagen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PATTERN(PATTERN)) u_gen_exp (
        .addr (cnt_nxt),
        .pass (issue_pass),
        .word (exp_word)
    );

    // Compare at the pipeline output; err_sum includes this cycle's result so
    // pass is correct on the same edge that enters DONE
    always_comb begin
        mismatch = pv[RD_LAT] && (ram_dout != pe[RD_LAT]);
        err_sum  = err_count + (ADDR_W+2)'(mismatch);
    end

    // Compare pipeline valid bits (only these need reset)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i <= RD_LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= issue_rd;
            for (int unsigned i = 1; i <= RD_LAT; i++) pv[i] <= pv[i-1];
        end
    end

    // Compare pipeline payload: address, pass and expected word
    always_ff @(posedge clk) begin
        pa[0] <= cnt_nxt;
        pp[0] <= issue_pass;
        pe[0] <= exp_word;
        for (int unsigned i = 1; i <= RD_LAT; i++) begin
            pa[i] <= pa[i-1];
            pp[i] <= pp[i-1];
            pe[i] <= pe[i-1];
        end
    end

    // Registered RAM port and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            ram_we   <= issue_we;
            ram_addr <= (issue_we || issue_rd) ? cnt_nxt : '0;
            ram_din  <= issue_we ? din_word : '0;
            busy     <= active_nxt;
            done     <= (state_nxt == ST_DONE);
            pass     <= (state_nxt == ST_DONE) && (err_sum == '0);
        end
    end

    // Error counter and first-failure capture, cleared on test launch
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            first_err_pass <= 1'b0;
        end else if (mismatch) begin
            err_count <= err_sum;
            if (err_count == '0) begin
                first_err_addr <= pa[RD_LAT];
                first_err_data <= ram_dout;
                first_err_pass <= pp[RD_LAT];
            end
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed self-checking bench for ram_bist_ctrl with behavioural RAM models
// (RD_LAT=1 with injectable faults, RD_LAT=3 fault-free).
module tb_ram_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start3;
    int          fault_mode;
    int          checks = 0;
    int          errors = 0;

    logic        busy1, done1, pass1, fep1, we1;
    logic [13:0] err1;
    logic [11:0] fea1, addr1;
    logic [7:0]  fed1, din1, dout1;

    logic        busy3, done3, pass3, fep3, we3;
    logic [13:0] err3;
    logic [11:0] fea3, addr3;
    logic [7:0]  fed3, din3, dout3;

    logic [7:0]  mem1 [0:4095];
    logic [7:0]  mem3 [0:4095];
    logic [7:0]  r3a, r3b;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_addr(fea1), .first_err_data(fed1), .first_err_pass(fep1),
        .ram_we(we1), .ram_addr(addr1), .ram_din(din1), .ram_dout(dout1)
    );

    ram_bist_ctrl #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_err_addr(fea3), .first_err_data(fed3), .first_err_pass(fep3),
        .ram_we(we3), .ram_addr(addr3), .ram_din(din3), .ram_dout(dout3)
    );

    // RD_LAT=1 RAM; fault_mode 1: bit0 of 0x123 stuck at 0, 2: addr[11] ignored
    always @(posedge clk) begin
        if (we1) begin
            if (fault_mode == 2)
                mem1[{1'b0, addr1[10:0]}] <= din1;
            else if (fault_mode == 1 && addr1 == 12'h123)
                mem1[addr1] <= din1 & 8'hFE;
            else
                mem1[addr1] <= din1;
        end
        dout1 <= (fault_mode == 2) ? mem1[{1'b0, addr1[10:0]}] : mem1[addr1];
    end

    // RD_LAT=3 RAM: three register stages on the read path
    always @(posedge clk) begin
        if (we3) mem3[addr3] <= din3;
        r3a   <= mem3[addr3];
        r3b   <= r3a;
        dout3 <= r3b;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller at the sample point of cycle 1
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_to_done(input int n0, output int done_cyc, output int busy_cyc);
        int n;
        n = n0;
        busy_cyc = 0;
        while (done1 !== 1'b1 && n < 20000) begin
            if (busy1 === 1'b1) busy_cyc++;
            step();
            n++;
        end
        done_cyc = (done1 === 1'b1) ? n : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done1); end
        checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass1); end
        checks++; if (err1 !== 14'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err1); end
        checks++; if ({we1, addr1, din1} !== 21'd0) begin errors++; $display("FAIL reset_ramport: got %h expected 0", {we1, addr1, din1}); end
        checks++; if ({fea1, fed1, fep1} !== 21'd0) begin errors++; $display("FAIL reset_first_err: got %h expected 0", {fea1, fed1, fep1}); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy3: got %b expected 0", busy3); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fault_free();
        int n, bc, bc2, dc;
        fault_mode = 0;
        pulse_start();
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL ff_busy_c1: got %b expected 1", busy1); end
        checks++; if ({we1, addr1, din1} !== {1'b1, 12'h000, 8'hA5}) begin errors++; $display("FAIL ff_wr_c1: got %h expected %h", {we1, addr1, din1}, {1'b1, 12'h000, 8'hA5}); end
        n = 1;
        bc = 0;
        while (n < 8193) begin
            if (busy1 === 1'b1) bc++;
            if (n == 2) begin
                checks++; if ({we1, addr1, din1} !== {1'b1, 12'h001, 8'hA4}) begin errors++; $display("FAIL ff_wr_c2: got %h expected %h", {we1, addr1, din1}, {1'b1, 12'h001, 8'hA4}); end
            end
            if (n == 4097) begin
                checks++; if ({we1, addr1} !== {1'b0, 12'h000}) begin errors++; $display("FAIL ff_rd0_c4097: got %h expected %h", {we1, addr1}, {1'b0, 12'h000}); end
            end
            if (n == 100) start = 1'b1;
            step();
            start = 1'b0;
            n++;
        end
        checks++; if ({we1, addr1, din1} !== {1'b1, 12'h000, 8'h5A}) begin errors++; $display("FAIL ff_wr1_c8193: got %h expected %h", {we1, addr1, din1}, {1'b1, 12'h000, 8'h5A}); end
        run_to_done(n, dc, bc2);
        checks++; if (dc != 16386) begin errors++; $display("FAIL ff_done_cycle: got %0d expected 16386", dc); end
        checks++; if (bc + bc2 != 16385) begin errors++; $display("FAIL ff_busy_cycles: got %0d expected 16385", bc + bc2); end
        checks++; if ({busy1, pass1} !== 2'b01) begin errors++; $display("FAIL ff_busy_pass: got %b expected 01", {busy1, pass1}); end
        checks++; if (err1 !== 14'd0) begin errors++; $display("FAIL ff_err_count: got %0d expected 0", err1); end
    endtask

    task automatic test_rd_lat3();
        int n, bc;
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        n = 1;
        bc = 0;
        while (done3 !== 1'b1 && n < 20000) begin
            if (busy3 === 1'b1) bc++;
            step();
            n++;
        end
        checks++; if (n != 16388) begin errors++; $display("FAIL lat3_done_cycle: got %0d expected 16388", n); end
        checks++; if (bc != 16387) begin errors++; $display("FAIL lat3_busy_cycles: got %0d expected 16387", bc); end
        checks++; if ({pass3, err3} !== {1'b1, 14'd0}) begin errors++; $display("FAIL lat3_result: got pass=%b err=%0d expected pass=1 err=0", pass3, err3); end
    endtask

    task automatic test_restart_stuck_bit();
        int dc, bc;
        fault_mode = 1;
        pulse_start();
        checks++; if ({done1, busy1, pass1} !== 3'b010) begin errors++; $display("FAIL restart_c1: got %b expected 010", {done1, busy1, pass1}); end
        run_to_done(1, dc, bc);
        checks++; if (dc != 16386) begin errors++; $display("FAIL stuck_done_cycle: got %0d expected 16386", dc); end
        checks++; if (err1 !== 14'd1) begin errors++; $display("FAIL stuck_err_count: got %0d expected 1", err1); end
        checks++; if ({fea1, fed1, fep1} !== {12'h123, 8'h96, 1'b0}) begin errors++; $display("FAIL stuck_first_err: got %h/%h/%b expected 123/96/0", fea1, fed1, fep1); end
        checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL stuck_pass: got %b expected 0", pass1); end
    endtask

    task automatic test_addr_alias();
        int dc, bc;
        fault_mode = 2;
        pulse_start();
        run_to_done(1, dc, bc);
        checks++; if (err1 !== 14'd4096) begin errors++; $display("FAIL alias_err_count: got %0d expected 4096", err1); end
        checks++; if ({fea1, fed1, fep1} !== {12'h000, 8'h2D, 1'b0}) begin errors++; $display("FAIL alias_first_err: got %h/%h/%b expected 000/2d/0", fea1, fed1, fep1); end
        checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL alias_pass: got %b expected 0", pass1); end
    endtask

    task automatic test_mid_reset();
        int n, dc, bc;
        fault_mode = 2;
        pulse_start();
        n = 1;
        while (n < 5000) begin
            step();
            n++;
        end
        checks++; if (err1 !== 14'd902) begin errors++; $display("FAIL midrst_err_before: got %0d expected 902", err1); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({busy1, we1, done1} !== 3'b000) begin errors++; $display("FAIL midrst_ctrl: got %b expected 000", {busy1, we1, done1}); end
        checks++; if (err1 !== 14'd0) begin errors++; $display("FAIL midrst_err: got %0d expected 0", err1); end
        checks++; if ({addr1, fed1} !== 20'd0) begin errors++; $display("FAIL midrst_addr_fed: got %h expected 0", {addr1, fed1}); end
        fault_mode = 0;
        pulse_start();
        run_to_done(1, dc, bc);
        checks++; if (dc != 16386) begin errors++; $display("FAIL midrst_done_cycle: got %0d expected 16386", dc); end
        checks++; if ({pass1, err1} !== {1'b1, 14'd0}) begin errors++; $display("FAIL midrst_result: got pass=%b err=%0d expected pass=1 err=0", pass1, err1); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start3 = 1'b0;
        fault_mode = 0;
        test_reset();
        fork
            test_fault_free();
            test_rd_lat3();
        join
        test_restart_stuck_bit();
        test_addr_alias();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
